// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory req/ready
// handshake, and absorbs bus-steal, branch redirects and hazard stalls.
module if_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd1,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        mem_busy,
    output logic        inst_req,
    output logic [15:0] inst_addr,
    input  logic [15:0] inst_rdata,
    input  logic        inst_ready,
    output logic [15:0] pc_out,
    output logic [15:0] instr_out,
    output logic        ifkeep
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_addr;
    logic [15:0] r_buf_pc;
    logic [15:0] r_buf_instr;
    logic [15:0] r_pc_out;
    logic [15:0] r_instr_out;
    logic        r_ifkeep;

    logic        w_req;
    logic        w_done;
    logic        w_redirect;
    logic [15:0] w_addr_next;
    logic [15:0] w_flush_pc;

    // NOTE: rst gates the request combinationally so it drops the instant reset asserts,
    // not at the next clock edge.
    assign w_req       = rst && (r_state == S_FETCH || r_state == S_FLUSH) && !mem_busy;
    assign w_done      = w_req && inst_ready;
    assign w_redirect  = !stall && branch_taken;
    assign w_addr_next = r_addr + PC_STEP;
    assign w_flush_pc  = w_redirect ? branch_target : r_pc;

    assign inst_req  = w_req;
    assign inst_addr = r_addr;
    assign pc_out    = r_pc_out;
    assign instr_out = r_instr_out;
    assign ifkeep    = r_ifkeep;

    // NOTE: all state, including the hold buffer, uses non-blocking assignments so every
    // branch below reads the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_buf_pc    <= '0;
            r_buf_instr <= NOP_INSTR;
            r_pc_out    <= '0;
            r_instr_out <= NOP_INSTR;
            r_ifkeep    <= 1'b1;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redirect) begin
                        r_pc        <= branch_target;
                        r_pc_out    <= '0;
                        r_instr_out <= NOP_INSTR;
                        r_ifkeep    <= 1'b1;
                        // An access still in flight must be drained before the new address is driven.
                        if (w_req && !w_done) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_addr <= branch_target;
                        end
                    end else if (w_done) begin
                        r_pc   <= w_addr_next;
                        r_addr <= w_addr_next;
                        if (stall) begin
                            r_buf_pc    <= r_addr;
                            r_buf_instr <= inst_rdata;
                            r_state     <= S_HOLD;
                        end else begin
                            r_pc_out    <= r_addr;
                            r_instr_out <= inst_rdata;
                            r_ifkeep    <= 1'b0;
                        end
                    end else if (!stall) begin
                        r_pc_out    <= '0;
                        r_instr_out <= NOP_INSTR;
                        r_ifkeep    <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (!stall) begin
                        r_state <= S_FETCH;
                        if (branch_taken) begin
                            r_pc        <= branch_target;
                            r_addr      <= branch_target;
                            r_pc_out    <= '0;
                            r_instr_out <= NOP_INSTR;
                            r_ifkeep    <= 1'b1;
                        end else begin
                            r_pc_out    <= r_buf_pc;
                            r_instr_out <= r_buf_instr;
                            r_ifkeep    <= 1'b0;
                        end
                    end
                end

                S_FLUSH: begin
                    r_pc <= w_flush_pc;
                    // Stale access ends either by completing or by losing the bus.
                    if (w_done || !w_req) begin
                        r_addr  <= w_flush_pc;
                        r_state <= S_FETCH;
                    end
                    if (!stall) begin
                        r_pc_out    <= '0;
                        r_instr_out <= NOP_INSTR;
                        r_ifkeep    <= 1'b1;
                    end
                end

                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a latency-programmable memory returning addr^A5A5
// and a per-cycle vector table, plus an async-reset-during-hold sequence.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        mem_busy;
    logic        inst_req;
    logic [15:0] inst_addr;
    logic [15:0] inst_rdata;
    logic        inst_ready;
    logic [15:0] pc_out;
    logic [15:0] instr_out;
    logic        ifkeep;

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    int cnt;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_busy      (mem_busy),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .inst_ready    (inst_ready),
        .pc_out        (pc_out),
        .instr_out     (instr_out),
        .ifkeep        (ifkeep)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: completes once a request has been held for 'lat' cycles; dropping req restarts it.
    assign inst_rdata = inst_addr ^ 16'hA5A5;
    assign inst_ready = inst_req && (cnt >= lat - 1);

    always @(posedge clk or negedge rst) begin
        if (!rst)                     cnt <= 0;
        else if (inst_req && !inst_ready) cnt <= cnt + 1;
        else                          cnt <= 0;
    end

    typedef struct {
        logic        st;
        logic        br;
        logic [15:0] tgt;
        logic        busy;
        int          lt;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic        e_keep;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl [NV];

    function automatic vec_t mk(logic st, logic br, logic [15:0] tgt, logic busy, int lt,
                                logic e_req, logic [15:0] e_addr,
                                logic [15:0] e_pc, logic [15:0] e_instr, logic e_keep);
        vec_t v;
        v.st = st; v.br = br; v.tgt = tgt; v.busy = busy; v.lt = lt;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_keep = e_keep;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] e_pc,
                              input logic [15:0] e_instr, input logic e_keep);
        check({tag, " pc_out"}, pc_out, e_pc);
        check({tag, " instr_out"}, instr_out, e_instr);
        check({tag, " ifkeep"}, {15'd0, ifkeep}, {15'd0, e_keep});
    endtask

    initial begin
        //           st br tgt       busy lat req addr      pc        instr     keep
        tbl[0]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 16'hA5A5, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0001, 16'h0001, 16'hA5A4, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0002, 16'h0002, 16'hA5A7, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0003, 16'h0003, 16'hA5A6, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 2, 1, 16'h0004, 16'h0000, 16'h0800, 1);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 2, 1, 16'h0004, 16'h0004, 16'hA5A1, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 2, 1, 16'h0005, 16'h0000, 16'h0800, 1);
        tbl[7]  = mk(1, 0, 16'h0000, 0, 2, 1, 16'h0005, 16'h0000, 16'h0800, 1);
        tbl[8]  = mk(1, 0, 16'h0000, 0, 2, 0, 16'h0006, 16'h0000, 16'h0800, 1);
        tbl[9]  = mk(1, 0, 16'h0000, 0, 2, 0, 16'h0006, 16'h0000, 16'h0800, 1);
        tbl[10] = mk(0, 0, 16'h0000, 0, 2, 0, 16'h0006, 16'h0005, 16'hA5A0, 0);
        tbl[11] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0006, 16'h0006, 16'hA5A3, 0);
        tbl[12] = mk(0, 0, 16'h0000, 0, 3, 1, 16'h0007, 16'h0000, 16'h0800, 1);
        tbl[13] = mk(0, 1, 16'h0040, 0, 3, 1, 16'h0007, 16'h0000, 16'h0800, 1);
        tbl[14] = mk(0, 0, 16'h0000, 0, 3, 1, 16'h0007, 16'h0000, 16'h0800, 1);
        tbl[15] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0040, 16'h0040, 16'hA5E5, 0);
        tbl[16] = mk(0, 1, 16'hFFFE, 0, 1, 1, 16'h0041, 16'h0000, 16'h0800, 1);
        tbl[17] = mk(0, 0, 16'h0000, 0, 2, 1, 16'hFFFE, 16'h0000, 16'h0800, 1);
        tbl[18] = mk(0, 0, 16'h0000, 1, 2, 0, 16'hFFFE, 16'h0000, 16'h0800, 1);
        tbl[19] = mk(0, 0, 16'h0000, 1, 2, 0, 16'hFFFE, 16'h0000, 16'h0800, 1);
        tbl[20] = mk(0, 0, 16'h0000, 0, 2, 1, 16'hFFFE, 16'h0000, 16'h0800, 1);
        tbl[21] = mk(0, 0, 16'h0000, 0, 2, 1, 16'hFFFE, 16'hFFFE, 16'h5A5B, 0);
        tbl[22] = mk(0, 0, 16'h0000, 0, 1, 1, 16'hFFFF, 16'hFFFF, 16'h5A5A, 0);
        tbl[23] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 16'hA5A5, 0);
        tbl[24] = mk(1, 1, 16'h1234, 0, 1, 1, 16'h0001, 16'h0000, 16'hA5A5, 0);
        tbl[25] = mk(0, 1, 16'h0100, 0, 1, 0, 16'h0002, 16'h0000, 16'h0800, 1);
        tbl[26] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0100, 16'h0100, 16'hA4A5, 0);
        tbl[27] = mk(0, 1, 16'h0200, 1, 1, 0, 16'h0101, 16'h0000, 16'h0800, 1);
        tbl[28] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0200, 16'h0200, 16'hA7A5, 0);
        tbl[29] = mk(0, 1, 16'h0300, 0, 3, 1, 16'h0201, 16'h0000, 16'h0800, 1);
        tbl[30] = mk(0, 0, 16'h0000, 1, 3, 0, 16'h0201, 16'h0000, 16'h0800, 1);
        tbl[31] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h0300, 16'h0300, 16'hA6A5, 0);
        tbl[32] = mk(1, 0, 16'h0000, 0, 2, 1, 16'h0301, 16'h0300, 16'hA6A5, 0);
        tbl[33] = mk(0, 0, 16'h0000, 0, 2, 1, 16'h0301, 16'h0301, 16'hA6A4, 0);

        rst           = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        mem_busy      = 1'b0;
        lat           = 1;

        #12;
        check("reset inst_req", {15'd0, inst_req}, 16'd0);
        check_outs("reset", 16'h0000, 16'h0800, 1'b1);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall         = tbl[i].st;
            branch_taken  = tbl[i].br;
            branch_target = tbl[i].tgt;
            mem_busy      = tbl[i].busy;
            lat           = tbl[i].lt;
            #1;
            check($sformatf("v%0d inst_req", i), {15'd0, inst_req}, {15'd0, tbl[i].e_req});
            check($sformatf("v%0d inst_addr", i), inst_addr, tbl[i].e_addr);
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_keep);
        end

        // Park a completed fetch in the hold buffer, then pulse reset between edges.
        stall         = 1'b1;
        branch_taken  = 1'b0;
        mem_busy      = 1'b0;
        lat           = 1;
        #1;
        check("hold entry inst_addr", inst_addr, 16'h0302);
        @(posedge clk);
        #1;
        check("hold inst_req", {15'd0, inst_req}, 16'd0);
        check_outs("hold", 16'h0301, 16'hA6A4, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async rst inst_req", {15'd0, inst_req}, 16'd0);
        check_outs("async rst", 16'h0000, 16'h0800, 1'b1);
        stall = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("restart inst_req", {15'd0, inst_req}, 16'd1);
        check("restart inst_addr", inst_addr, 16'h0000);
        @(posedge clk);
        #1;
        check_outs("restart", 16'h0000, 16'hA5A5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
